// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder
//   Direct-mapped, read-only instruction cache in front of a 64-bit burst
//   memory. Lookups are combinational, so a hit answers in the same cycle.
//   A miss is allowed to start a 4-beat line fill only while the stall
//   control unit keeps continue_i_cache high.
//
// Ports
//   clk                in   system clock, rising edge
//   rst                in   synchronous active-low reset
//   instr_mem_read     in   fetch request, held until instr_mem_resp
//   instr_mem_address  in   fetch byte address (bits [1:0] ignored)
//   continue_i_cache   in   0 forbids starting a new fill
//   instr_mem_rdata    out  fetched instruction word
//   instr_mem_resp     out  instr_mem_rdata is valid this cycle
//   pmem_read          out  burst read request to memory
//   pmem_address       out  line-aligned burst address
//   pmem_rdata         in   burst beat data
//   pmem_resp          in   one beat is valid on pmem_rdata
module icache_fetch_responder #(
  parameter int S_INDEX = 5,
  parameter int BEATS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_mem_read,
  input  logic [31:0] instr_mem_address,
  input  logic        continue_i_cache,
  output logic [31:0] instr_mem_rdata,
  output logic        instr_mem_resp,
  output logic        pmem_read,
  output logic [31:0] pmem_address,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [26:0]            lineAddr_q, lineAddr_d;
  logic [BEATS-1:0][63:0] lineBuf_q;
  logic [SETS-1:0]        valid_q;
  logic [TAG_W-1:0]       tag_q [SETS];
  logic [255:0]           data_q [SETS];

  logic [S_INDEX-1:0]     reqIndex;
  logic [TAG_W-1:0]       reqTag;
  logic [2:0]             reqWord;
  logic                   hit;
  logic                   lastBeat;
  logic [S_INDEX-1:0]     fillIndex;
  logic                   unusedAddrBits;

  // Byte offset within the word carries no information for instruction fetch.
  assign unusedAddrBits = ^instr_mem_address[1:0];

  assign reqIndex  = instr_mem_address[4+S_INDEX:5];
  assign reqTag    = instr_mem_address[31:5+S_INDEX];
  assign reqWord   = instr_mem_address[4:2];
  assign fillIndex = lineAddr_q[S_INDEX-1:0];
  assign lastBeat  = (cnt_q == 2'(BEATS - 1));

  assign hit = instr_mem_read && valid_q[reqIndex] && (tag_q[reqIndex] == reqTag);

  // Word mux is always live; it only matters when instr_mem_resp is high.
  assign instr_mem_rdata = data_q[reqIndex][{reqWord, 5'b0} +: 32];

  // The latched line address drives memory for the whole fill, so a
  // changing fetch address cannot disturb a burst in flight.
  assign pmem_address = {lineAddr_q, 5'b0};

  // Next-state and output decode. continue_i_cache only gates the IDLE->FILL
  // transition; once a burst has begun it always runs to completion.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lineAddr_d     = lineAddr_q;
    instr_mem_resp = 1'b0;
    pmem_read      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          instr_mem_resp = 1'b1;
        end else if (instr_mem_read && continue_i_cache) begin
          lineAddr_d = instr_mem_address[31:5];
          cnt_d      = 2'd0;
          state_d    = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (lastBeat) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and valid bits. Reset clears every valid bit, which also
  // leaves any set that was mid-fill invalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      lineAddr_q <= 27'd0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lineAddr_q <= lineAddr_d;
      if (state_q == WRITE) begin
        valid_q[fillIndex] <= 1'b1;
      end
    end
  end

  // Data-path storage carries no reset; it is qualified by valid_q.
  // Beat 0 lands in the least significant 64 bits of the line.
  always_ff @(posedge clk) begin
    if (rst && state_q == FILL && pmem_resp) begin
      lineBuf_q[cnt_q] <= pmem_rdata;
    end
    if (rst && state_q == WRITE) begin
      tag_q[fillIndex]  <= lineAddr_q[26:S_INDEX];
      data_q[fillIndex] <= lineBuf_q;
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// tb_icache_fetch_responder
//   Directed plus randomized checks of icache_fetch_responder against a
//   transaction-level model: a lazily randomized backing memory and a
//   per-set valid/tag table. Cycle expectations follow the documented miss
//   timeline (miss, FILL beats with optional memory stalls, WRITE, hit).
module tb_icache_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_mem_read;
  logic [31:0] instr_mem_address;
  logic        continue_i_cache;
  logic [31:0] instr_mem_rdata;
  logic        instr_mem_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  icache_fetch_responder #(.S_INDEX(5), .BEATS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_mem_read   (instr_mem_read),
    .instr_mem_address(instr_mem_address),
    .continue_i_cache (continue_i_cache),
    .instr_mem_rdata  (instr_mem_rdata),
    .instr_mem_resp   (instr_mem_resp),
    .pmem_read        (pmem_read),
    .pmem_address     (pmem_address),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Backing memory: 64-bit beats keyed by 8-byte-aligned address.
  logic [63:0] memBeats [logic [31:0]];
  // Cache model: one valid bit and 22-bit tag per set.
  bit          mValid [32];
  logic [21:0] mTag   [32];
  logic [31:0] fillLine;
  int          beatCnt;

  function automatic logic [63:0] memBeat(input logic [31:0] a);
    logic [31:0] key;
    key = {a[31:3], 3'b000};
    if (!memBeats.exists(key)) memBeats[key] = {$urandom, $urandom};
    return memBeats[key];
  endfunction

  function automatic bit modelHit(input logic [31:0] a);
    return mValid[a[9:5]] && (mTag[a[9:5]] == a[31:10]);
  endfunction

  function automatic logic [31:0] expWord(input logic [31:0] a);
    logic [63:0] beat;
    beat = memBeat(a);
    return a[2] ? beat[63:32] : beat[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, answer memory there, then
  // advance to just after the next rising edge.
  task automatic cycleCheck(input string tag, input bit expResp, input bit expPread,
                            input logic [31:0] dataExp, input bit stall);
    @(negedge clk);
    checkOutput({tag, "_resp"}, 32'(instr_mem_resp), 32'(expResp));
    checkOutput({tag, "_pread"}, 32'(pmem_read), 32'(expPread));
    if (expPread) checkOutput({tag, "_paddr"}, pmem_address, fillLine);
    if (expResp) checkOutput({tag, "_rdata"}, instr_mem_rdata, dataExp);
    if (expPread && !stall && beatCnt < 4) begin
      pmem_resp  = 1'b1;
      pmem_rdata = memBeat(fillLine + 32'(beatCnt * 8));
      beatCnt++;
    end
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = {$urandom, $urandom};
  endtask

  // Miss cycle through WRITE. Optionally holds continue_i_cache low first,
  // and optionally moves the fetch address after the first FILL cycle.
  task automatic doMiss(input logic [31:0] a, input int noCont, input logic [15:0] stallMask,
                        input bit doSwitch, input logic [31:0] switchAddr);
    int fc;
    instr_mem_read    = 1'b1;
    instr_mem_address = a;
    continue_i_cache  = 1'b0;
    for (int i = 0; i < noCont; i++) cycleCheck("nocont", 1'b0, 1'b0, 32'd0, 1'b0);
    continue_i_cache = 1'b1;
    fillLine = {a[31:5], 5'b0};
    beatCnt  = 0;
    cycleCheck("miss", 1'b0, 1'b0, 32'd0, 1'b0);
    fc = 0;
    while (beatCnt < 4 && fc < 24) begin
      if (doSwitch && fc == 1) instr_mem_address = switchAddr;
      continue_i_cache = 1'($urandom_range(0, 1));
      cycleCheck("fill", 1'b0, 1'b1, 32'd0, (fc < 16) ? stallMask[fc] : 1'b0);
      fc++;
    end
    continue_i_cache = 1'b1;
    cycleCheck("write", 1'b0, 1'b0, 32'd0, 1'b0);
    mValid[a[9:5]] = 1'b1;
    mTag[a[9:5]]   = a[31:10];
  endtask

  task automatic applyStimulus(input logic [31:0] a, input int noCont, input logic [15:0] stallMask);
    instr_mem_read    = 1'b1;
    instr_mem_address = a;
    continue_i_cache  = 1'b1;
    if (!modelHit(a)) doMiss(a, noCont, stallMask, 1'b0, 32'd0);
    instr_mem_address = a;
    cycleCheck("hit", 1'b1, 1'b0, expWord(a), 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] pool [6];
    logic [31:0] a;
    rst               = 1'b0;
    instr_mem_read    = 1'b1;
    instr_mem_address = 32'h0000_0060;
    continue_i_cache  = 1'b1;
    pmem_resp         = 1'b0;
    pmem_rdata        = 64'd0;
    for (int i = 0; i < 32; i++) mValid[i] = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_resp", 32'(instr_mem_resp), 32'd0);
    checkOutput("reset_pread", 32'(pmem_read), 32'd0);
    checkOutput("reset_paddr", pmem_address, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic miss/fill/hit, then a same-line hit on the last word.
    applyStimulus(32'h0000_0060, 0, 16'h0000);
    applyStimulus(32'h0000_007C, 0, 16'h0000);

    // Fill held off by continue_i_cache for 3 cycles.
    applyStimulus(32'h0000_1000, 3, 16'h0000);

    // Address changes mid-fill with two stall cycles between beats.
    doMiss(32'h0000_2000, 0, 16'b0000_0000_0000_0110, 1'b1, 32'h0000_3000);
    applyStimulus(32'h0000_3000, 0, 16'h0000);

    // Same-index conflict evicts and refills.
    applyStimulus(32'h0000_0000, 0, 16'h0000);
    applyStimulus(32'h0000_0400, 0, 16'h0000);
    applyStimulus(32'h0000_0000, 0, 16'h0000);

    // Hit held while the pipeline is frozen.
    instr_mem_read    = 1'b1;
    instr_mem_address = 32'h0000_0060;
    continue_i_cache  = 1'b0;
    for (int i = 0; i < 5; i++) cycleCheck("hold", 1'b1, 1'b0, expWord(32'h0000_0060), 1'b0);

    // Reset on the third FILL beat.
    a                 = 32'h0000_0140;
    instr_mem_address = a;
    continue_i_cache  = 1'b1;
    fillLine          = {a[31:5], 5'b0};
    beatCnt           = 0;
    cycleCheck("rst_miss", 1'b0, 1'b0, 32'd0, 1'b0);
    cycleCheck("rst_fill0", 1'b0, 1'b1, 32'd0, 1'b0);
    cycleCheck("rst_fill1", 1'b0, 1'b1, 32'd0, 1'b0);
    rst = 1'b0;
    cycleCheck("rst_fill2", 1'b0, 1'b1, 32'd0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
    applyStimulus(a, 0, 16'h0000);
    applyStimulus(32'h0000_0060, 0, 16'h0000);

    // Randomized fetches over a small pool of lines to mix hits and conflicts.
    pool[0] = 32'h0000_0060;
    pool[1] = 32'h0000_0000;
    pool[2] = 32'h0000_0400;
    pool[3] = 32'h8000_0060;
    pool[4] = 32'h0000_1000;
    pool[5] = $urandom;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        instr_mem_read   = 1'b0;
        continue_i_cache = 1'b1;
        cycleCheck("idle", 1'b0, 1'b0, 32'd0, 1'b0);
      end
      a = pool[$urandom_range(0, 5)];
      a = {a[31:5], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      applyStimulus(a, $urandom_range(0, 2), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
